// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// Frame on dout, LSB first: start (0), WIDTH data bits, [parity], stop (1).
// Bits advance only on clk edges where the enable bit-rate tick is high.
// Optional parity bit: define SERIAL_FRAME_TX_PARITY_EN (PARITY_ODD selects sense).
module serial_frame_tx #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  shreg_shr;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dout_q, dout_d;
    logic              done_q, done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    // Parity of the accepted word, captured at accept so din may change afterwards.
    logic              par_q, par_d;
`else
    logic              unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    // Next-state and next-output logic; every state holds unless enable ticks.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        shreg_shr = shreg_q >> 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                dout_d = 1'b1;
                // Accept does not wait for enable; the start bit begins right away.
                if (din_valid) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    state_d = S_START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    par_d   = (^din) ^ PARITY_ODD;
`endif
                end
            end
            S_START: begin
                if (enable) begin
                    dout_d  = shreg_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (enable) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        dout_d  = par_q;
                        state_d = S_PARITY;
`else
                        dout_d  = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shreg_d = shreg_shr;
                        dout_d  = shreg_shr[0];
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
                if (enable) begin
                    dout_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (enable) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = 1'b1;
            end
        endcase
    end

    // State registers; clear wins over everything and abandons any frame.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign din_ready = (state_q == S_IDLE) && !clear;
    assign busy      = (state_q != S_IDLE);
    assign dout      = dout_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: table-driven frames plus hand sequences for the
// held-valid, mid-frame clear and parity cases. Expected serial bits are
// queued at each accept and popped at every bit boundary.
module tb_serial_frame_tx;

    localparam int WIDTH      = 8;
    localparam bit PARITY_ODD = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int FL = WIDTH + 3;
    localparam int NV = 4;
`else
    localparam int FL = WIDTH + 2;
    localparam int NV = 5;
`endif

    logic             clk;
    logic             clear;
    logic             enable;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             din_ready;
    logic             dout;
    logic             busy;
    logic             done;

    serial_frame_tx #(.WIDTH(WIDTH), .PARITY_ODD(PARITY_ODD)) dut (
        .clk       (clk),
        .clear     (clear),
        .enable    (enable),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .dout      (dout),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic d;
        logic done;
        logic busy;
    } elem_t;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               period;
        logic [FL-1:0]    frame;
    } vec_t;

    elem_t sb_q[$];
    elem_t last;
    bit    active;
    bit    mon_on;
    bit    acc_exp;
    int    pop_cnt;
    int    checks;
    int    passes;
    int    en_period;
    bit    en_e, acc_e, clr_e;
    vec_t  vecs[NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [FL-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        return {1'b1, (^w) ^ PARITY_ODD, w, 1'b0};
`else
        return {1'b1, w, 1'b0};
`endif
    endfunction

    // Bit-rate tick: high on one cycle in every en_period.
    initial begin
        int ecnt;
        ecnt   = 0;
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ecnt++;
            enable = ((ecnt % en_period) == 0);
        end
    end

    // Capture what the edge saw.
    always @(posedge clk) begin
        en_e  = enable;
        acc_e = acc_exp;
        clr_e = clear;
    end

    // Scoreboard monitor: pop at bit boundaries, otherwise expect the line held.
    always @(negedge clk) begin
        elem_t e;
        logic  exp_done;
        exp_done = 1'b0;
        if (clr_e) begin
            sb_q.delete();
            active = 1'b0;
            last   = '{1'b1, 1'b0, 1'b0};
            mon_on = 1'b1;
        end else if (mon_on && (acc_e || (en_e && active))) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1'b1, 1'b0);
            end else begin
                e        = sb_q.pop_front();
                last     = e;
                active   = e.busy;
                exp_done = e.done;
                pop_cnt++;
            end
        end
        if (mon_on) begin
            check("dout", dout, last.d);
            check("busy", busy, active);
            check("done", done, exp_done);
            check("din_ready", din_ready, !clear && !active);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [FL-1:0] f);
        for (int i = 0; i < FL; i++) sb_q.push_back('{f[i], 1'b0, 1'b1});
        sb_q.push_back('{1'b1, 1'b1, 1'b0});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active || sb_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input logic [FL-1:0] f);
        wait_idle();
        din_valid = 1'b1;
        din       = w;
        acc_exp   = 1'b1;
        push_frame(f);
        tick();
        din_valid = 1'b0;
        acc_exp   = 1'b0;
        din       = WIDTH'($urandom);
    endtask

    initial begin
        int base, n;
        checks    = 0;
        passes    = 0;
        pop_cnt   = 0;
        active    = 1'b0;
        mon_on    = 1'b0;
        acc_exp   = 1'b0;
        last      = '{1'b1, 1'b0, 1'b0};
        en_period = 1;
        clear     = 1'b1;
        din_valid = 1'b0;
        din       = '0;

`ifdef SERIAL_FRAME_TX_PARITY_EN
        vecs[0] = '{8'hA5, 1, 11'b10101001010};
        vecs[1] = '{8'h07, 1, 11'b11000001110};
        vecs[2] = '{8'h07, 3, 11'b11000001110};
        vecs[3] = '{8'h3C, 4, 11'b10001111000};
`else
        vecs[0] = '{8'hA5, 1, 10'b1101001010};
        vecs[1] = '{8'h3C, 4, 10'b1001111000};
        vecs[2] = '{8'h00, 1, 10'b1000000000};
        vecs[3] = '{8'hFF, 3, 10'b1111111110};
        vecs[4] = '{8'h81, 2, 10'b1100000010};
`endif

        // Reset held for two edges, then released.
        tick();
        tick();
        check("rst_ready_low", din_ready, 1'b0);
        clear = 1'b0;
        tick();
        check("rst_dout", dout, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", din_ready, 1'b1);

        // Table of frames at various bit rates.
        for (int v = 0; v < NV; v++) begin
            en_period = vecs[v].period;
            send(vecs[v].word, vecs[v].frame);
            wait_idle();
        end

        // din_valid held high with din churning: only the word present when
        // the block is idle again gets taken.
        en_period = 1;
        wait_idle();
        din_valid = 1'b1;
        din       = 8'hF0;
        acc_exp   = 1'b1;
        push_frame(frame_of(8'hF0));
        tick();
        acc_exp = 1'b0;
        n = 0;
        do begin
            din = WIDTH'($urandom);
            tick();
            n++;
        end while (active && n < 100);
        if (n >= 100) check("hold_timeout", 1'b1, 1'b0);
        din     = WIDTH'($urandom);
        acc_exp = 1'b1;
        push_frame(frame_of(din));
        tick();
        acc_exp = 1'b0;
        din     = WIDTH'($urandom);
        tick();
        din_valid = 1'b0;
        wait_idle();

        // Clear during data bit 3 abandons the frame; the next one is clean.
        en_period = 2;
        wait_idle();
        base = pop_cnt;
        send(8'h55, frame_of(8'h55));
        n = 0;
        while ((pop_cnt - base) < 5 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("clr_timeout", 1'b1, 1'b0);
        clear = 1'b1;
        tick();
        check("clr_dout", dout, 1'b1);
        check("clr_busy", busy, 1'b0);
        clear = 1'b0;
        tick();
        send(8'h81, frame_of(8'h81));
        wait_idle();

        repeat (6) tick();
        check("sb_empty", sb_q.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter; the transmit end of the serial bit stream that the flip-flop based receive/sampling logic captures on `din`.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first on a single registered line.
- Frame is: start bit (0), data bits, stop bit (1).
- Bit timing is set by the `enable` strobe, a one-cycle bit-rate tick, so the line rate is decoupled from `clk`.

Parameters:
- WIDTH, 8, data bits per frame (legal range 1..32).
- PARITY_ODD, 0, parity sense when PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- enable  input  1  bit-rate tick; the FSM advances only on edges where enable=1.
- din_valid  input  1  `din` holds a word to send.
- din  input  WIDTH  parallel data word.
- din_ready  output  1  block can accept a word (high only in IDLE).
- dout  output  1  serial line, registered; idles high.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset:
  - clear is sampled on the rising edge of clk; reset is synchronous and active-high.
  - After the reset edge: state=IDLE, dout=1, done=0, busy=0, shift register=0, bit count=0.
  - While clear=1, din_ready is forced to 0 combinationally.
  - clear has priority over every other input.
- States: IDLE, START, DATA, STOP (plus PARITY when compiled in).
- IDLE:
  - din_ready=1 and dout=1.
  - On an edge with din_valid=1 (enable not required): latch din into the shift register, set dout<=0 and bit count<=0, go to START.
  - din may change freely after the accept edge.
- START: on the next edge with enable=1, dout<=shreg[0] and go to DATA.
- DATA, on each edge with enable=1:
  - If bit count == WIDTH-1: dout<=1 and go to STOP.
  - Otherwise: shift right, dout<=next bit, bit count += 1.
- STOP: on an edge with enable=1, go to IDLE; done<=1 for exactly one cycle; dout stays 1.
- Holding: with enable=0, state and dout are held, so each bit lasts from one enable edge to the next.
- Frame length:
  - With enable tied high, the frame is WIDTH+2 cycles of dout after the accept edge.
  - done is high in the cycle after the stop bit.
  - din_ready returns high in that same cycle.
  - Minimum gap between frames is zero idle bit periods, but one clk cycle in IDLE is required to accept the next word.
- Handshake:
  - Transfer happens only when din_valid && din_ready.
  - din_valid asserted while busy is ignored; the word is not queued.
  - din_ready does not depend on din_valid.
- Clear mid-frame: at the next edge the frame is abandoned, dout=1, busy=0, and no done pulse is issued.
- Bit count is $clog2(WIDTH)+1 bits wide and never wraps within a frame.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - On the last DATA enable edge, dout<=parity bit, computed as the XOR of the latched word, XORed with PARITY_ODD.
  - The next enable edge goes to STOP with dout<=1.
  - Frame is WIDTH+3 bits.
- Undefined: no PARITY state or logic; frame is WIDTH+2 bits; PARITY_ODD has no effect.

Test Plan:
1. Hold clear for 2 cycles, then release -> dout=1, busy=0, done=0, din_ready=1; din_ready=0 while clear=1.
2. WIDTH=8, enable=1, send 8'hA5 -> dout over 10 cycles = 0,1,0,1,0,0,1,0,1,1; done high for 1 cycle after the stop bit; din_ready high again in that cycle.
3. enable pulsing 1 cycle in 4, send 8'h3C -> each data and stop bit held exactly 4 cycles; serial bits 0,0,0,1,1,1,1,0,0,1; busy high throughout.
4. din_valid held high with din changing every cycle during a frame of 8'hF0 -> 8'hF0 is sent intact; only the din value present on the first cycle din_ready is high again is accepted next.
5. Assert clear during data bit 3 of 8'h55 -> next edge dout=1, busy=0, no done; a following 8'h81 frame is sent correctly.
6. With SERIAL_FRAME_TX_PARITY_EN, send 8'h07 -> parity bit 1 when PARITY_ODD=0, 0 when PARITY_ODD=1; frame is 11 bits, then stop=1.
